sdram_arbiter: RTL

// - Multi-master front end for sdram_controller. Collects requests from NUM_MASTERS clients and picks one
//   per transaction by round-robin. Drives the controller's request interface from registers.
// - Routes the controller's tagged valid/complete pulses back to the owning client.
// - Sits between CPU/cache/DMA/video masters and sdram_controller.

---
 rtl/sdram_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin front end that lets NUM_MASTERS clients share one
// sdram_controller request port.
//
// Handshake: a client raises m_req with stable fields and keeps them stable
// through the cycle m_ack pulses. Towards the controller, sdram_request plus the
// sdram_* fields are registered and frozen until sdram_ready is high in a cycle
// where sdram_request is high; that cycle is the accept and the m_ack cycle.
// Once raised, sdram_request is never withdrawn before accept.
//
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   m_req/m_write/...   per-master request fields (slice i belongs to master ID i+1)
//   m_ack               one-hot accept pulse back to the granted master
//   m_rdata/m_valid/m_complete  read return path, decoded from controller tags
//   sdram_*  (out)      registered request to the controller
//   sdram_rdata/valid/complete/ready (in)  controller responses
//   state_dbg           current FSM state (0 = IDLE, 1 = HOLD)
module sdram_arbiter #(
  parameter int NUM_MASTERS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_write,
  input  logic [NUM_MASTERS*26-1:0] m_address,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  input  logic [NUM_MASTERS*4-1:0]  m_byte_en,
  input  logic [NUM_MASTERS-1:0]    m_burst,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [31:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]    m_valid,
  output logic [NUM_MASTERS-1:0]    m_complete,
  output logic                      sdram_request,
  output logic [3:0]                sdram_master,
  output logic                      sdram_write,
  output logic [25:0]               sdram_address,
  output logic [31:0]               sdram_wdata,
  output logic [3:0]                sdram_byte_en,
  output logic                      sdram_burst,
  input  logic [31:0]               sdram_rdata,
  input  logic [3:0]                sdram_valid,
  input  logic [3:0]                sdram_complete,
  input  logic                      sdram_ready,
  output logic                      state_dbg
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state, state_next;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  grant_idx;
  logic [IW-1:0]  pick_idx;
  logic           pick_found;
  logic [N-1:0]   busy;
  logic [N-1:0]   eligible;
  logic           accept;

  // A master with a read in flight is masked until its completion tag shows up.
  assign eligible  = m_req & ~busy;
  assign accept    = (state == HOLD) && sdram_ready;
  assign state_dbg = state;
  assign m_rdata   = sdram_rdata;

  function automatic logic [IW-1:0] wrap_idx(input int unsigned v);
    return IW'(v % N);
  endfunction

  // Search from rr_ptr upwards. Walking the offsets downward lets the last hit,
  // i.e. the smallest offset from rr_ptr, win without a break.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[wrap_idx(int'(rr_ptr) + k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // m_ack is gated by reset so a request dropped by reset is never acknowledged.
  always_comb begin
    state_next = state;
    m_ack      = '0;
    case (state)
      IDLE: begin
        if (pick_found) state_next = HOLD;
      end
      HOLD: begin
        if (sdram_ready) begin
          state_next = IDLE;
          if (reset) m_ack[grant_idx] = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr        <= '0;
      grant_idx     <= '0;
      busy          <= '0;
      sdram_request <= 1'b0;
      sdram_master  <= '0;
      sdram_write   <= 1'b0;
      sdram_address <= '0;
      sdram_wdata   <= '0;
      sdram_byte_en <= '0;
      sdram_burst   <= 1'b0;
    end else begin
      if ((state == IDLE) && pick_found) begin
        grant_idx     <= pick_idx;
        sdram_request <= 1'b1;
        sdram_master  <= 4'(pick_idx) + 4'd1;
        sdram_write   <= m_write[pick_idx];
        sdram_address <= m_address[26*int'(pick_idx) +: 26];
        sdram_wdata   <= m_wdata[32*int'(pick_idx) +: 32];
        sdram_byte_en <= m_byte_en[4*int'(pick_idx) +: 4];
        sdram_burst   <= m_burst[pick_idx];
      end else if (accept) begin
        sdram_request <= 1'b0;
        rr_ptr        <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (sdram_complete == 4'(i + 1)) busy[i] <= 1'b0;
      end
      // A busy master is never granted, so this set cannot collide with a clear.
      if (accept && !sdram_write) busy[grant_idx] <= 1'b1;
    end
  end

  // Tags are master IDs; 0 and IDs above N decode to nothing.
  always_comb begin
    m_valid    = '0;
    m_complete = '0;
    for (int i = 0; i < N; i++) begin
      m_valid[i]    = (sdram_valid == 4'(i + 1));
      m_complete[i] = (sdram_complete == 4'(i + 1));
    end
  end

endmodule
